// File: rtl/read_buffer_fifo.sv
// read_buffer_fifo
//   Read-path helper for the PageRank engine. It captures one FULL_WIDTH-bit
//   read line and emits its slots [base, min(bounds, SLOTS)) one per cycle
//   into a show-ahead FIFO. It also provides a combinational selector that
//   picks one WIDTH-bit word out of a line.
//
// Ports
//   clk, reset_n             clock (rising edge) and asynchronous active-low reset
//   line_valid, line_data    read-data beat and its line
//   line_base, line_bounds   slot window [base, bounds); bounds is clamped to SLOTS
//   busy                     a line is held and its slots are still being emitted
//   overrun                  one-cycle pulse: a line arrived while busy and was dropped
//   fifo_rdreq               pop request
//   fifo_q                   head element (0 when the FIFO is empty)
//   fifo_empty, fifo_full    occupancy flags, derived from fifo_count
//   fifo_count               number of elements held
//   sel_line, sel_idx        line and word index for the selector
//   sel_word                 selected word, 0 when sel_idx >= SLOTS
module read_buffer_fifo #(
    parameter  int FULL_WIDTH = 512,
    parameter  int WIDTH      = 64,
    parameter  int LOG_DEPTH  = 4,
    localparam int SLOTS      = FULL_WIDTH / WIDTH,
    localparam int IDX_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  line_valid,
    input  logic [FULL_WIDTH-1:0] line_data,
    input  logic [7:0]            line_base,
    input  logic [7:0]            line_bounds,
    output logic                  busy,
    input  logic                  fifo_rdreq,
    output logic [WIDTH-1:0]      fifo_q,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [LOG_DEPTH:0]    fifo_count,
    output logic                  overrun,
    input  logic [FULL_WIDTH-1:0] sel_line,
    input  logic [IDX_W-1:0]      sel_idx,
    output logic [WIDTH-1:0]      sel_word
);

    // Slot-position arithmetic is wide enough for the 8-bit base/bounds and for SLOTS.
    localparam int              PW      = (IDX_W + 1 > 9) ? IDX_W + 1 : 9;
    localparam int              DEPTH   = 1 << LOG_DEPTH;
    localparam logic [PW-1:0]   SLOTS_P = PW'(SLOTS);

    logic [WIDTH-1:0]     line_slots_next [SLOTS];
    logic [WIDTH-1:0]     line_slots_reg  [SLOTS];
    logic [WIDTH-1:0]     sel_slots       [SLOTS];
    logic [WIDTH-1:0]     mem_reg         [DEPTH];

    logic [PW-1:0]        idx_reg;
    logic [PW-1:0]        end_reg;
    logic                 busy_reg;
    logic                 overrun_reg;
    logic [LOG_DEPTH-1:0] wr_ptr_reg;
    logic [LOG_DEPTH-1:0] rd_ptr_reg;
    logic [LOG_DEPTH:0]   count_reg;

    logic [PW-1:0]        base_ext;
    logic [PW-1:0]        bounds_ext;
    logic [PW-1:0]        end_next;
    logic                 capture;
    logic                 pop;
    logic                 push;
    logic                 last;
    logic [WIDTH-1:0]     push_data;

    // Unpack both lines into slot arrays.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slots
        assign line_slots_next[gi] = line_data[WIDTH*gi +: WIDTH];
        assign sel_slots[gi]       = sel_line[WIDTH*gi +: WIDTH];
    end

    assign base_ext   = PW'(line_base);
    assign bounds_ext = PW'(line_bounds);
    assign end_next   = (bounds_ext > SLOTS_P) ? SLOTS_P : bounds_ext;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (LOG_DEPTH+1)'(DEPTH));
    assign fifo_count = count_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

    assign capture   = line_valid && !busy_reg;
    assign pop       = fifo_rdreq && !fifo_empty;
    // A same-edge pop frees the slot, so a full FIFO can still take a push.
    assign push      = busy_reg && (!fifo_full || pop);
    assign last      = ((idx_reg + PW'(1)) == end_reg);
    assign push_data = line_slots_reg[idx_reg[IDX_W-1:0]];

    // Show-ahead head; forced to 0 when empty so stale entries never leak out.
    assign fifo_q = fifo_empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg     <= '0;
            end_reg     <= '0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            overrun_reg <= line_valid && busy_reg;

            if (capture) begin
                idx_reg  <= base_ext;
                end_reg  <= end_next;
                // An empty window leaves the buffer idle.
                busy_reg <= (base_ext < end_next);
            end else if (push) begin
                idx_reg <= idx_reg + PW'(1);
                if (last) begin
                    busy_reg <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + LOG_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + LOG_DEPTH'(1);
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + (LOG_DEPTH+1)'(1);
                2'b01:   count_reg <= count_reg - (LOG_DEPTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Datapath storage carries no reset; validity is tracked by busy and count.
    always_ff @(posedge clk) begin
        if (capture) begin
            line_slots_reg <= line_slots_next;
        end
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        sel_word = '0;
        if (int'(sel_idx) < SLOTS) begin
            sel_word = sel_slots[sel_idx];
        end
    end

endmodule

// File: tb/tb_read_buffer_fifo.sv
module tb_read_buffer_fifo;

    logic         clk = 1'b0;
    logic         reset_n;

    // Default instance: WIDTH=64, SLOTS=8, depth 16.
    logic         line_valid;
    logic [511:0] line_data;
    logic [7:0]   line_base;
    logic [7:0]   line_bounds;
    logic         busy;
    logic         fifo_rdreq;
    logic [63:0]  fifo_q;
    logic         fifo_empty;
    logic         fifo_full;
    logic [4:0]   fifo_count;
    logic         overrun;
    logic [511:0] sel_line;
    logic [2:0]   sel_idx;
    logic [63:0]  sel_word;

    // Wide instance: WIDTH=128, SLOTS=4.
    logic         line_valid2;
    logic [511:0] line_data2;
    logic [7:0]   line_base2;
    logic [7:0]   line_bounds2;
    logic         busy2;
    logic         fifo_rdreq2;
    logic [127:0] fifo_q2;
    logic         fifo_empty2;
    logic         fifo_full2;
    logic [4:0]   fifo_count2;
    logic         overrun2;
    logic [511:0] sel_line2;
    logic [1:0]   sel_idx2;
    logic [127:0] sel_word2;

    int n_assert = 0;
    int n_fail   = 0;

    read_buffer_fifo dut (
        .clk(clk), .reset_n(reset_n),
        .line_valid(line_valid), .line_data(line_data),
        .line_base(line_base), .line_bounds(line_bounds),
        .busy(busy), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .overrun(overrun), .sel_line(sel_line), .sel_idx(sel_idx), .sel_word(sel_word)
    );

    read_buffer_fifo #(.FULL_WIDTH(512), .WIDTH(128), .LOG_DEPTH(4)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .line_valid(line_valid2), .line_data(line_data2),
        .line_base(line_base2), .line_bounds(line_bounds2),
        .busy(busy2), .fifo_rdreq(fifo_rdreq2), .fifo_q(fifo_q2),
        .fifo_empty(fifo_empty2), .fifo_full(fifo_full2), .fifo_count(fifo_count2),
        .overrun(overrun2), .sel_line(sel_line2), .sel_idx(sel_idx2), .sel_word(sel_word2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build a 64-bit-slot line with slot i = start + i.
    function automatic logic [511:0] mk_line(input logic [63:0] start);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = start + 64'(i);
        return l;
    endfunction

    // Wait (bounded) for the buffer to go idle, then present one line for one edge.
    task automatic send_line(input logic [511:0] d, input logic [7:0] b, input logic [7:0] e);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle", busy, 1'b0);
        line_data   = d;
        line_base   = b;
        line_bounds = e;
        line_valid  = 1'b1;
        tick();
        line_valid  = 1'b0;
    endtask

    initial begin
        logic [511:0] line1;
        logic [63:0]  expq [$];
        int           n;

        reset_n = 1'b0;
        line_valid = 1'b0; line_data = '0; line_base = '0; line_bounds = '0;
        fifo_rdreq = 1'b0; sel_line = '0; sel_idx = '0;
        line_valid2 = 1'b0; line_data2 = '0; line_base2 = '0; line_bounds2 = '0;
        fifo_rdreq2 = 1'b0; sel_line2 = '0; sel_idx2 = '0;

        // Reset state
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_q", fifo_q, 64'd0);
        #3 reset_n = 1'b1;
        tick();

        // 1: full line, continuous pop
        line1 = mk_line(64'h10);
        fifo_rdreq = 1'b1;
        send_line(line1, 8'd0, 8'd8);
        chk("t1_busy_cap", busy, 1'b1);
        chk("t1_empty_cap", fifo_empty, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t1_q%0d", k), fifo_q, 64'h10 + 64'(k));
            chk($sformatf("t1_busy%0d", k), busy, (k < 7) ? 1'b1 : 1'b0);
        end
        tick();
        chk("t1_final_count", fifo_count, 5'd0);
        chk("t1_final_empty", fifo_empty, 1'b1);

        // 2: partial window 3..5
        send_line(line1, 8'd3, 8'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t2_q%0d", k), fifo_q, 64'h13 + 64'(k));
        end
        chk("t2_busy_done", busy, 1'b0);
        tick();
        chk("t2_empty", fifo_empty, 1'b1);
        // empty window
        send_line(line1, 8'd5, 8'd5);
        chk("t2_empty_win_busy", busy, 1'b0);
        tick();
        chk("t2_empty_win_count", fifo_count, 5'd0);

        // 3: three lines with no pops, then drain
        fifo_rdreq = 1'b0;
        for (int l = 1; l <= 3; l++) begin
            send_line(mk_line(64'(l) * 64'h100), 8'd0, 8'd8);
            for (int i = 0; i < 8; i++) expq.push_back(64'(l) * 64'h100 + 64'(i));
        end
        for (int i = 0; i < 10; i++) tick();
        chk("t3_full", fifo_full, 1'b1);
        chk("t3_count", fifo_count, 5'd16);
        chk("t3_busy_stall", busy, 1'b1);
        fifo_rdreq = 1'b1;
        n = 0;
        while (expq.size() > 0) begin
            chk($sformatf("t3_drain%0d", n), fifo_q, expq.pop_front());
            tick();
            n++;
        end
        chk("t3_drained_empty", fifo_empty, 1'b1);
        chk("t3_drained_busy", busy, 1'b0);

        // 4: overrun while busy
        send_line(mk_line(64'h40), 8'd0, 8'd4);
        chk("t4_busy", busy, 1'b1);
        line_data  = mk_line(64'h900);
        line_base  = 8'd0;
        line_bounds = 8'd8;
        line_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                chk("t4_overrun_pulse", overrun, 1'b1);
                line_valid = 1'b0;
            end
            if (k == 1) chk("t4_overrun_clear", overrun, 1'b0);
            chk($sformatf("t4_q%0d", k), fifo_q, 64'h40 + 64'(k));
        end
        tick();
        chk("t4_no_extra", fifo_empty, 1'b1);
        chk("t4_idle", busy, 1'b0);

        // Reset mid-emission
        fifo_rdreq = 1'b0;
        send_line(line1, 8'd0, 8'd8);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_empty", fifo_empty, 1'b1);
        chk("t4_rst_count", fifo_count, 5'd0);
        chk("t4_rst_q", fifo_q, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // 5: word select
        sel_line = line1;
        for (int i = 0; i < 8; i++) begin
            sel_idx = 3'(i);
            #1;
            chk($sformatf("t5_sel%0d", i), sel_word, 64'h10 + 64'(i));
        end

        // 6: WIDTH=128, bounds clamped from 9 to 4
        for (int i = 0; i < 4; i++) line_data2[128*i +: 128] = 128'hA0 + 128'(i);
        fifo_rdreq2  = 1'b1;
        line_base2   = 8'd0;
        line_bounds2 = 8'd9;
        line_valid2  = 1'b1;
        tick();
        line_valid2  = 1'b0;
        chk("t6_busy", busy2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_q%0d", k), fifo_q2, 128'hA0 + 128'(k));
        end
        chk("t6_busy_done", busy2, 1'b0);
        tick();
        chk("t6_empty", fifo_empty2, 1'b1);
        sel_line2 = line_data2;
        sel_idx2  = 2'd3;
        #1;
        chk("t6_sel3", sel_word2, 128'hA3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
